// File: rtl/icache_refill_axi_pkg.sv
// icache_refill_axi_pkg: AXI read encodings, refill FSM states and line geometry shared by the refill engine
package icache_refill_axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_OFFSET_W = $clog2(LINE_WORDS_DEF * 4);
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} refill_state_t;
  function automatic int line_offset_w(input int words);
    return $clog2(words * 4);
  endfunction
endpackage

// File: rtl/icache_refill_linebuf.sv
// icache_refill_linebuf: line buffer where beat k lands in word (start + k) mod LINE_WORDS
module icache_refill_linebuf
  import icache_refill_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  localparam int IW = $clog2(LINE_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [IW-1:0]                start,
  input  logic [IW-1:0]                beat,
  input  logic [DATA_W-1:0]            wdata,
  output logic [LINE_WORDS*DATA_W-1:0] line_data
);
  logic [LINE_WORDS-1:0][DATA_W-1:0] words;
  logic [IW-1:0] slot;
  assign slot = start + beat;
  // capture each accepted beat into its rotated word slot; untouched words hold
  always_ff @(posedge clk or negedge rst)
    if (!rst) words <= '0;
    else if (we) words[slot] <= wdata;
  assign line_data = words;
endmodule

// File: rtl/icache_refill_axi.sv
// icache_refill_axi: I-cache miss refill over one AXI4 read burst; ICACHE_REFILL_WRAP_EN selects critical-word-first WRAP bursts
module icache_refill_axi
  import icache_refill_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_WORDS = 4,
  parameter int AXI_ID = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  output logic                         req_err,
  output logic [LINE_WORDS*DATA_W-1:0] line_data,
`ifdef ICACHE_REFILL_WRAP_EN
  output logic                         crit_valid,
  output logic [DATA_W-1:0]            crit_word,
`endif
  output logic [3:0]                   arid,
  output logic [ADDR_W-1:0]            araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int OFF = line_offset_w(LINE_WORDS);
`ifdef ICACHE_REFILL_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [1:0] BURST = BURST_WRAP;
`else
  localparam logic WRAP_EN = 1'b0;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'((1 << OFF) - 1);
  localparam logic [1:0] BURST = BURST_INCR;
`endif
  refill_state_t state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [IW-1:0] cnt, start;
  logic abandon, err, skip, beat, take;
  logic unused;
  assign unused = ^rid;
  assign beat = state == ST_R && rvalid;
  assign take = state == ST_IDLE && req_valid && !skip;
  assign arid = 4'(AXI_ID);
  assign araddr = addr;
  assign arlen = 8'(LINE_WORDS - 1);
  assign arsize = SIZE_4B;
  assign arburst = BURST;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_next;
  // next state plus AXI and controller strobes decoded from the registered state
  always_comb begin
    arvalid = state == ST_AR;
    rready = state == ST_R;
    req_ready = state == ST_DONE && !abandon;
    req_err = state == ST_DONE && err && !abandon;
    state_next = state == ST_IDLE ? (take ? ST_AR : ST_IDLE) :
                 state == ST_AR   ? (arready ? ST_R : ST_AR) :
                 state == ST_R    ? (rvalid && rlast ? ST_DONE : ST_R) : ST_IDLE;
  end
  // request latch, beat counter, abandon and error tracking; skip blanks IDLE for one cycle after DONE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr <= '0;
      start <= '0;
      cnt <= '0;
      abandon <= 1'b0;
      err <= 1'b0;
      skip <= 1'b0;
    end else begin
      skip <= state == ST_DONE;
      if (take) begin
        addr <= req_addr & ALIGN;
        start <= WRAP_EN ? req_addr[OFF-1:2] : '0;
        cnt <= '0;
        abandon <= 1'b0;
        err <= 1'b0;
      end
      if ((state == ST_AR || state == ST_R) && !req_valid) abandon <= 1'b1;
      if (beat) begin
        cnt <= cnt + 1'b1;
        err <= err | (rresp != RESP_OKAY) | (rlast && cnt != IW'(LINE_WORDS - 1));
      end
    end
`ifdef ICACHE_REFILL_WRAP_EN
  // forward the first beat of each burst as the critical word
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      crit_valid <= 1'b0;
      crit_word <= '0;
    end else begin
      crit_valid <= beat && cnt == '0;
      if (beat && cnt == '0) crit_word <= rdata;
    end
`endif
  icache_refill_linebuf #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_linebuf (
    .clk(clk),
    .rst(rst),
    .we(beat),
    .start(start),
    .beat(cnt),
    .wdata(rdata),
    .line_data(line_data)
  );
endmodule
